// File: rtl/pwm_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_arb_pkg : shared types, widths and register map for the PWM arbiter    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pwm_arb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam logic [ADDR_W-1:0] REG_PERIOD_L  = 6'h00;
  localparam logic [ADDR_W-1:0] REG_PERIOD_H  = 6'h01;
  localparam logic [ADDR_W-1:0] REG_EN        = 6'h02;
  localparam logic [ADDR_W-1:0] REG_CMP1_L    = 6'h03;
  localparam logic [ADDR_W-1:0] REG_CMP1_H    = 6'h04;
  localparam logic [ADDR_W-1:0] REG_CMP2_L    = 6'h05;
  localparam logic [ADDR_W-1:0] REG_CMP2_H    = 6'h06;
  localparam logic [ADDR_W-1:0] REG_CNT_RST   = 6'h07;
  localparam logic [ADDR_W-1:0] REG_CNT_L     = 6'h08;
  localparam logic [ADDR_W-1:0] REG_CNT_H     = 6'h09;
  localparam logic [ADDR_W-1:0] REG_PRESCALE  = 6'h0A;
  localparam logic [ADDR_W-1:0] REG_UPDOWN    = 6'h0B;
  localparam logic [ADDR_W-1:0] REG_PWM_EN    = 6'h0C;
  localparam logic [ADDR_W-1:0] REG_FUNCTIONS = 6'h0D;

  function automatic logic reg_is_mapped(input logic [ADDR_W-1:0] a);
    return a <= REG_FUNCTIONS;
  endfunction

  function automatic logic reg_is_ro(input logic [ADDR_W-1:0] a);
    return (a == REG_CNT_L) || (a == REG_CNT_H);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_regs_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_regs_arbiter_if : one requester port of the PWM register arbiter       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface pwm_regs_arbiter_if;
  import pwm_arb_pkg::*;

  logic              valid;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, write, addr, wdata, lock, input ack, rdata);
  modport slave  (input valid, write, addr, wdata, lock, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/pwm_arb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_arb_rr_pick : 2-way grant picker, fixed priority or round-robin        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pwm_arb_rr_pick (
  input  wire logic [1:0] valid_i,
  input  wire logic [1:0] eligible_i,
  input  wire logic       ptr_i,
  input  wire logic       mode_i,
  output logic            grant_o,
  output logic            gnt_id_o
);
  logic [1:0] w_req;

  assign w_req   = valid_i & eligible_i;
  assign grant_o = |w_req;

  // ptr_i names the master preferred on a tie; fixed mode always prefers req0
  always_comb begin
    gnt_id_o = 1'b0;
    if (w_req == 2'b11) gnt_id_o = mode_i ? ptr_i : 1'b0;
    else                gnt_id_o = w_req[1];
  end
endmodule
`default_nettype wire

// File: rtl/pwm_regs_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_regs_arbiter : two-master arbiter for the PWM register-file bus        |
// | Optional lock timeout: define PWM_ARB_LOCK_TIMEOUT_EN.  Rev 1.0            |
// +----------------------------------------------------------------------------+
module pwm_regs_arbiter
  import pwm_arb_pkg::*;
#(
  parameter int ARB_MODE     = 1,
  parameter int LOCK_TIMEOUT = 64
) (
  input  wire logic              clk,
  input  wire logic              rst,
  pwm_regs_arbiter_if.slave      req0_if,
  pwm_regs_arbiter_if.slave      req1_if,
  output logic                   read_o,
  output logic                   write_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [DATA_W-1:0]      data_write_o,
  input  wire logic [DATA_W-1:0] data_read_i,
  output logic                   owner_o,
  output logic                   busy_o,
  output logic                   lock_timeout_o
);
  if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
    $error("LOCK_TIMEOUT must be at least 1");
  end

  arb_state_e        state_q;
  logic              read_q, write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_write_q;
  logic              owner_q, ptr_q, lock_q;
  logic              lat_write_q, lat_lock_q;

  logic [1:0]        w_valid, w_elig;
  logic              w_grant, w_gnt_id, w_resp, w_to_fire;
  logic              w_sel_write, w_sel_lock;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_valid = {req1_if.valid, req0_if.valid};
  assign w_elig  = lock_q ? (owner_q ? 2'b10 : 2'b01) : 2'b11;

  pwm_arb_rr_pick u_pick (
    .valid_i    (w_valid),
    .eligible_i (w_elig),
    .ptr_i      (ptr_q),
    .mode_i     (ARB_MODE != 0),
    .grant_o    (w_grant),
    .gnt_id_o   (w_gnt_id)
  );

  assign w_sel_write = w_gnt_id ? req1_if.write : req0_if.write;
  assign w_sel_lock  = w_gnt_id ? req1_if.lock  : req0_if.lock;
  assign w_sel_addr  = w_gnt_id ? req1_if.addr  : req0_if.addr;
  assign w_sel_wdata = w_gnt_id ? req1_if.wdata : req0_if.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_write_q <= '0;
      owner_q      <= 1'b0;
      ptr_q        <= 1'b0;
      lock_q       <= 1'b0;
      lat_write_q  <= 1'b0;
      lat_lock_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_to_fire) lock_q <= 1'b0;
          // strobes are launched at the grant edge so they appear in ISSUE
          if (w_grant) begin
            state_q      <= ST_ISSUE;
            owner_q      <= w_gnt_id;
            ptr_q        <= ~w_gnt_id;
            addr_q       <= w_sel_addr;
            data_write_q <= w_sel_wdata;
            lat_write_q  <= w_sel_write;
            lat_lock_q   <= w_sel_lock;
            write_q      <= w_sel_write;
            read_q       <= ~w_sel_write;
          end
        end
        ST_ISSUE: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          lock_q  <= lat_lock_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w_resp = (state_q == ST_RESP);

  assign req0_if.ack   = w_resp & ~owner_q;
  assign req1_if.ack   = w_resp &  owner_q;
  assign req0_if.rdata = (w_resp && !owner_q && !lat_write_q) ? data_read_i : '0;
  assign req1_if.rdata = (w_resp &&  owner_q && !lat_write_q) ? data_read_i : '0;

  assign read_o       = read_q;
  assign write_o      = write_q;
  assign addr_o       = addr_q;
  assign data_write_o = data_write_q;
  assign owner_o      = owner_q;
  assign busy_o       = (state_q != ST_IDLE) || lock_q;

`ifdef PWM_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             to_pulse_q;
  logic             w_owner_valid, w_to_run, w_owner_grant;

  assign w_owner_valid = owner_q ? req1_if.valid : req0_if.valid;
  assign w_to_run      = lock_q && (state_q == ST_IDLE) && !w_owner_valid;
  assign w_to_fire     = w_to_run && (to_cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
  assign w_owner_grant = (state_q == ST_IDLE) && w_grant && (w_gnt_id == owner_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q   <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      to_pulse_q <= w_to_fire;
      if (w_to_fire || w_owner_grant || !lock_q) to_cnt_q <= '0;
      else if (w_to_run)                         to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign lock_timeout_o = to_pulse_q;
`else
  assign w_to_fire      = 1'b0;
  assign lock_timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire
